// File: rtl/tnoc_vc_port_scheduler_if.sv
// Handshake bundle between the input-port/VC request side and the output-port
// scheduler. The master drives flit requests and flow control; the slave
// (scheduler) returns grants and the head of the packet-order FIFO.
interface tnoc_vc_port_scheduler_if #(
    parameter int PORTS      = 5,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 2
);
    localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [PORTS*CHANNELS-1:0] request;
    logic [PORTS*CHANNELS-1:0] start_of_packet;
    logic [PORTS*CHANNELS-1:0] end_of_packet;
    logic [CHANNELS-1:0]       vc_available;
    logic [PORTS*CHANNELS-1:0] grant;
    logic [PORTS-1:0]          output_grant;
    logic [VW-1:0]             output_vc;
    logic                      output_free;
    logic [CW-1:0]             fifo_count;

    modport master (
        output request, start_of_packet, end_of_packet, vc_available, output_free,
        input  grant, output_grant, output_vc, fifo_count
    );

    modport slave (
        input  request, start_of_packet, end_of_packet, vc_available, output_free,
        output grant, output_grant, output_vc, fifo_count
    );
endinterface

// File: rtl/tnoc_vc_port_scheduler.sv
// Output-port scheduler: per-VC port arbitration with packet locking, then a
// VC stage that grants one flit per cycle, plus a FIFO recording the order in
// which packet heads were accepted so the output stage can follow it.
module tnoc_vc_port_scheduler #(
    parameter int PORTS       = 5,
    parameter int CHANNELS    = 2,
    parameter int FIFO_DEPTH  = 2,
    parameter int VC_PRIORITY = 0,
    parameter int INTERLEAVE  = 0
) (
    input  logic clk,
    input  logic rst,
    tnoc_vc_port_scheduler_if.slave bus
);
    localparam int PW = $clog2(PORTS);
    localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (PORTS * CHANNELS > 1) ? $clog2(PORTS * CHANNELS) : 1;

    // Lock / pointer state
    logic [CHANNELS-1:0] port_lock;
    logic [PW-1:0]       locked_port [CHANNELS];
    logic [PW-1:0]       port_ptr    [CHANNELS];
    logic                vc_lock;
    logic [VW-1:0]       locked_vc;
    logic [VW-1:0]       vc_ptr;

    // Packet-order FIFO
    logic [PORTS-1:0]    fifo_port [FIFO_DEPTH];
    logic [VW-1:0]       fifo_vc   [FIFO_DEPTH];
    logic [FW-1:0]       rd_ptr;
    logic [FW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    // Arbitration results
    logic [PW-1:0]       cand_port [CHANNELS];
    logic [CHANNELS-1:0] cand_req;
    logic [CHANNELS-1:0] cand_head;
    logic [CHANNELS-1:0] cand_tail;
    logic [CHANNELS-1:0] eligible;
    logic                sel_valid;
    logic [VW-1:0]       sel_vc;
    logic [PW-1:0]       sel_port;
    logic                sel_head;
    logic                sel_tail;
    logic                xfer;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;

    function automatic logic [IW-1:0] flat_idx(input logic [PW-1:0] p, input logic [VW-1:0] v);
        return IW'(int'(p) * CHANNELS + int'(v));
    endfunction

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (int'(p) == PORTS - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [VW-1:0] next_vc(input logic [VW-1:0] v);
        return (int'(v) == CHANNELS - 1) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [FW-1:0] next_slot(input logic [FW-1:0] s);
        return (int'(s) == FIFO_DEPTH - 1) ? '0 : s + 1'b1;
    endfunction

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Port stage: per VC pick the locked owner, or round-robin among head flits
    always_comb begin
        logic [PW-1:0] p;
        p = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            cand_port[v] = '0;
            cand_req[v]  = 1'b0;
            cand_head[v] = 1'b0;
            cand_tail[v] = 1'b0;
            if (port_lock[v]) begin
                cand_port[v] = locked_port[v];
                cand_req[v]  = bus.request[flat_idx(locked_port[v], VW'(v))];
                cand_tail[v] = bus.end_of_packet[flat_idx(locked_port[v], VW'(v))];
            end else begin
                // Walk from lowest to highest priority so the last hit wins
                for (int i = PORTS - 1; i >= 0; i--) begin
                    p = PW'((int'(port_ptr[v]) + i) % PORTS);
                    if (bus.request[flat_idx(p, VW'(v))] && bus.start_of_packet[flat_idx(p, VW'(v))]) begin
                        cand_port[v] = p;
                        cand_req[v]  = 1'b1;
                        cand_head[v] = 1'b1;
                        cand_tail[v] = bus.end_of_packet[flat_idx(p, VW'(v))];
                    end
                end
            end
            // A head needs a FIFO slot; the same-cycle pop does not count
            eligible[v] = cand_req[v] & bus.vc_available[v] & ~(cand_head[v] & fifo_full);
        end
    end

    // VC stage: held VC, fixed priority (highest index) or round-robin
    always_comb begin
        logic [VW-1:0] vc;
        vc        = '0;
        sel_valid = 1'b0;
        sel_vc    = '0;
        if (INTERLEAVE == 0 && vc_lock) begin
            sel_valid = eligible[locked_vc];
            sel_vc    = locked_vc;
        end else if (VC_PRIORITY != 0) begin
            for (int v = 0; v < CHANNELS; v++) begin
                if (eligible[v]) begin
                    sel_valid = 1'b1;
                    sel_vc    = VW'(v);
                end
            end
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                vc = VW'((int'(vc_ptr) + i) % CHANNELS);
                if (eligible[vc]) begin
                    sel_valid = 1'b1;
                    sel_vc    = vc;
                end
            end
        end
    end

    assign xfer     = sel_valid & ~rst;
    assign sel_port = cand_port[sel_vc];
    assign sel_head = cand_head[sel_vc];
    assign sel_tail = cand_tail[sel_vc];
    assign push     = xfer & sel_head;
    assign pop      = bus.output_free & ~fifo_empty;

    // Drive the single one-hot grant for the selected port/VC
    always_comb begin
        bus.grant = '0;
        if (xfer) begin
            bus.grant[flat_idx(sel_port, sel_vc)] = 1'b1;
        end
    end

    // Lock and round-robin pointer updates on each flit transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            port_lock <= '0;
            vc_lock   <= 1'b0;
            locked_vc <= '0;
            vc_ptr    <= '0;
            for (int v = 0; v < CHANNELS; v++) begin
                port_ptr[v] <= '0;
            end
        end else if (xfer) begin
            if (sel_head) begin
                port_ptr[sel_vc] <= next_port(sel_port);
                if (!sel_tail) begin
                    port_lock[sel_vc] <= 1'b1;
                end
            end else if (sel_tail) begin
                port_lock[sel_vc] <= 1'b0;
            end
            if (INTERLEAVE == 0) begin
                if (sel_head && !sel_tail) begin
                    vc_lock   <= 1'b1;
                    locked_vc <= sel_vc;
                end else if (sel_tail) begin
                    vc_lock <= 1'b0;
                end
            end
            if (VC_PRIORITY == 0 && (INTERLEAVE != 0 || sel_tail)) begin
                vc_ptr <= next_vc(sel_vc);
            end
        end
    end

    // Owner port of each locked VC; only meaningful while port_lock is set
    always_ff @(posedge clk) begin
        if (push && !sel_tail) begin
            locked_port[sel_vc] <= sel_port;
        end
    end

    // FIFO occupancy and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_slot(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_slot(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage for {one-hot port, vc} of each accepted head
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_port[wr_ptr] <= PORTS'(1) << sel_port;
            fifo_vc[wr_ptr]   <= sel_vc;
        end
    end

    assign bus.output_grant = fifo_empty ? '0 : fifo_port[rd_ptr];
    assign bus.output_vc    = (CHANNELS == 1 || fifo_empty) ? '0 : fifo_vc[rd_ptr];
    assign bus.fifo_count   = count;
endmodule
